// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types for the nibble-serial subtractor.
// Nibble width and the sequencer state encoding.
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_bla.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin.
// Purely combinational; all borrows in flattened form.
module borrow_lookahead_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign c[0] = bin;
  assign c[1] = g[0]
              | (p[0] & c[0]);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d    = a ^ b ^ c[3:0];
  assign bout = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial a - b - bin with start/busy/done handshake.
// Optional ovf output enabled by NIBBLE_SUB_OVF_EN.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
`ifdef NIBBLE_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  state_t           state_d;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             brw_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             done_q;
  logic [3:0]       na;
  logic [3:0]       nb;
  logic [3:0]       nd;
  logic             nbo;
  logic             last;
  logic             accept;
  logic             run;

  assign run    = (state == RUN);
  assign accept = (state == IDLE) && start;
  assign last   = (idx == IW'(N - 1));

  assign na = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign nb = b_q[idx*NIBBLE_W +: NIBBLE_W];

  borrow_lookahead_sub4 u_slice (
    .a    (na),
    .b    (nb),
    .bin  (brw_q),
    .d    (nd),
    .bout (nbo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        brw_q  <= bin;
        idx    <= '0;
        diff_q <= '0;
      end else if (run) begin
        diff_q[idx*NIBBLE_W +: NIBBLE_W] <= nd;
        brw_q <= nbo;
        idx   <= idx + 1'b1;
        if (last) begin
          bout_q <= nbo;
          done_q <= 1'b1;
        end
      end
    end
  end

`ifdef NIBBLE_SUB_OVF_EN
  logic ovf_q;
  logic brw_msb;

  // Borrow into the top bit recovered from d3 = a3 ^ b3 ^ brw3.
  assign brw_msb = nd[3] ^ na[3] ^ nb[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (run && last && !accept) begin
      ovf_q <= brw_msb ^ nbo;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = run;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: vector table, scoreboard,
// busy-ignore, back-to-back and mid-run reset sequences.
module tb_nibble_serial_subtractor;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef NIBBLE_SUB_OVF_EN
  logic         ovf;
`endif

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef NIBBLE_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ovf_model(input logic [15:0] x,
                                     input logic [15:0] y,
                                     input logic c);
    int r;
    r = int'($signed(x)) - int'($signed(y)) - (c ? 1 : 0);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_done: got done=1 expected no done");
      end else begin
        mon_e = sbq.pop_front();
        chk("diff", diff, mon_e.d);
        chk("bout", bout, mon_e.bo);
        chk("latency", cyc - mon_e.acc, N);
        chk("busy_at_done", busy, 1'b0);
`ifdef NIBBLE_SUB_OVF_EN
        chk("ovf", ovf, mon_e.ov);
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic ibin, input logic [15:0] ed,
                          input logic eb);
    exp_t e;
    int   t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    e.d = ed;
    e.bo = eb;
    e.ov = ovf_model(ia, ib, ibin);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (n_done < target) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got %0d dones expected %0d",
               n_done, target);
    end
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{16'h000B, 16'h0006, 1'b0, 16'h0005, 1'b0};
    vt[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vt[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[3]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vt[4]  = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0};
    vt[5]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
    vt[6]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
    vt[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vt[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
    vt[9]  = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1};
    vt[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1};
    vt[11] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};

    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_bout", bout, 1'b0);
`ifdef NIBBLE_SUB_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bo);
      a = ~vt[i].a;
      b = ~vt[i].b;
      bin = ~vt[i].bin;
      exp_done++;
      wait_done(exp_done);
      @(negedge clk);
      chk("diff_hold", diff, vt[i].d);
      chk("done_pulse", done, 1'b0);
    end

    // Start held while busy with new operands, then re-accepted on done.
    start_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
    exp_done++;
    a = 16'hFFFF;
    b = 16'h0000;
    start = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1'b1);
    a = 16'h0010;
    b = 16'h0001;
    bin = 1'b0;
    begin
      exp_t e;
      e.d = 16'h000F;
      e.bo = 1'b0;
      e.ov = ovf_model(16'h0010, 16'h0001, 1'b0);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    chk("no_bubble_busy", busy, 1'b1);
    exp_done++;
    wait_done(exp_done);
    repeat (6) @(negedge clk);
    chk("done_count", n_done, exp_done);

    // Leave bout=1 so a mid-run reset visibly clears it.
    start_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    exp_done++;
    wait_done(exp_done);
    @(negedge clk);

    start_op(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_diff", diff, 16'h0000);
    chk("midrst_bout", bout, 1'b0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", n_done, exp_done);

    start_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0);
    exp_done++;
    wait_done(exp_done);
    @(negedge clk);
    chk("post_rst_diff", diff, 16'h000F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Computes diff = a − b − bin over WIDTH-bit unsigned operands, four bits per clock. It is the inverse-direction companion to the team's 4-bit carry-lookahead adder. Each cycle reuses one 4-bit borrow-lookahead slice, and the borrow is chained between nibbles in a register. A start/busy/done handshake sits in front of the datapath, so the block plugs into multi-cycle ALU sequencing.

Parameters:
- WIDTH, 16: operand/result width. Must be a multiple of 4 and at least 4.
- N (localparam), WIDTH/4: number of nibble steps.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only when busy=0.
- a  in  WIDTH  minuend. Latched at accept.
- b  in  WIDTH  subtrahend. Latched at accept.
- bin  in  1  borrow-in. Latched at accept.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when diff and bout are valid.
- diff  out  WIDTH  result, a − b − bin mod 2^WIDTH.
- bout  out  1  borrow-out. 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, diff=0, bout=0; nibble index=0; operand and borrow registers cleared.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch a, b and bin, clear the index, go to RUN, set busy=1.
  - RUN: each edge computes nibble[idx] through the slice using the chained borrow. The result nibble is written into diff[4*idx+3:4*idx], the borrow register is updated, and idx increments. At the edge processing idx=N−1: bout is updated, done=1, busy=0, state goes to IDLE.
- Latency: start accepted at edge k gives done=1 during the cycle after edge k+N. For WIDTH=16 that is 4 cycles.
- diff is cleared to 0 at accept and filled nibble by nibble. It is valid only when done=1, and holds until the next accept.
- done is high for exactly one cycle.
- start while busy=1 is ignored. Operands are not re-sampled.
- start during the done cycle (state is IDLE) is accepted: back-to-back operation with no bubble.
- Borrow-lookahead slice, per bit i:
  - g_i = ~a_i & b_i
  - p_i = ~(a_i ^ b_i)
  - brw_{i+1} = g_i | (p_i & brw_i)
  - d_i = a_i ^ b_i ^ brw_i
  - All four borrows are computed in flattened lookahead form, not rippled.
- Reset mid-RUN: everything returns to reset values immediately, and no done is produced.
- Inputs a, b and bin may change freely after accept without affecting the result.

Optional Feature:
- Macro: NIBBLE_SUB_OVF_EN.
- Defined: adds output ovf (out, 1). It is the two's-complement overflow of the full-width subtract, = brw_into_msb ^ bout. ovf is registered with bout, valid on done, reset 0, and holds until the next accept.
- Undefined: no ovf port and no associated logic.

Decomposition:
- Shared package: NIBBLE_W=4, and a state typedef with values IDLE and RUN.
- Natural sub-module: borrow_lookahead_sub4. Ports: a[3:0], b[3:0], bin → d[3:0], bout. It is purely combinational and is instantiated once.

Test Plan:
- WIDTH=16, a=0x000B, b=0x0006, bin=0 → exactly 4 cycles after the accept edge: done=1, diff=0x0005, bout=0; busy falls with done.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. Then a=0xFFFF, b=0xFFFF, bin=1 → diff=0xFFFF, bout=1.
- Start accepted with a=0x1234, b=0x0234. Assert start with a=0xFFFF while busy → ignored; done once, diff=0x1000.
- Start reasserted in the done cycle with a=0x0010, b=0x0001 → accepted; second done 4 cycles later, diff=0x000F, and no idle bubble between operations.
- rst_n pulsed low at RUN cycle 2 → busy, done, diff and bout all 0 immediately; no done follows; the next start works normally.
- NIBBLE_SUB_OVF_EN: a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1. Then a=0x0005, b=0x0003 → ovf=0.
